// File: rtl/linear_accum_scheduler.sv
// Fully-connected layer scheduler. Takes pCHANNEL-wide input chunks from the
// upstream FIFO and sweeps each one across every output group. For each group
// it issues a weight-ROM read, then a PE enable one cycle later, then an
// accumulator write pPE_LATENCY cycles after that. After the last chunk the
// MAC pipeline drains, and the group results are streamed out under
// valid/ready.
module linear_accum_scheduler #(
   parameter  int pIN_FEATURE      = 6272,
   parameter  int pOUT_FEATURE     = 128,
   parameter  int pCHANNEL         = 32,
   parameter  int pOUTPUT_PARALLEL = 4,
   parameter  int pPE_LATENCY      = 3,
   localparam int NCHUNK = pIN_FEATURE / pCHANNEL,
   localparam int NGROUP = pOUT_FEATURE / pOUTPUT_PARALLEL,
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1,
   localparam int GW     = (NGROUP > 1) ? $clog2(NGROUP) : 1,
   localparam int AW     = (NCHUNK * NGROUP > 1) ? $clog2(NCHUNK * NGROUP) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          w_rd_en,
   output logic [AW-1:0] w_addr,
   output logic          pe_en,
   output logic          acc_wr_en,
   output logic [GW-1:0] acc_addr,
   output logic          acc_clr,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [GW-1:0] out_idx,
   output logic          done
);

   // state   | meaning
   // IDLE    | waiting for en
   // LOAD    | in_ready high, waiting for the next input chunk
   // COMPUTE | one output group per cycle: weight read + issue into MAC pipe
   // DRAIN   | all chunks issued, waiting for the last accumulator write
   // OUTPUT  | presenting finished group results downstream
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_COMPUTE,
      ST_DRAIN,
      ST_OUTPUT
   } state_t;

   // Stage 0 lines up with pe_en; the last stage lines up with acc_wr_en.
   localparam int DEPTH = 1 + pPE_LATENCY;
   localparam logic [GW-1:0] LAST_GRP   = GW'(NGROUP - 1);
   localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

   state_t                     r_state, w_state_nxt;
   logic [CW-1:0]              r_chunk, w_chunk_nxt;
   logic [GW-1:0]              r_grp, w_grp_nxt;
   logic [DEPTH-1:0]           r_dl_valid;
   logic [DEPTH-1:0]           r_dl_first;
   logic [DEPTH-1:0][GW-1:0]   r_dl_grp;

   logic                       w_last_grp;
   logic                       w_last_chunk;
   logic                       w_dl_empty;
   logic [AW-1:0]              w_row;

   assign w_last_grp   = (r_grp == LAST_GRP);
   assign w_last_chunk = (r_chunk == LAST_CHUNK);
   assign w_dl_empty   = ~|r_dl_valid;
   assign w_row        = AW'(r_chunk) * AW'(NGROUP) + AW'(r_grp);

   // State and loop counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_chunk <= '0;
         r_grp   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_chunk <= w_chunk_nxt;
         r_grp   <= w_grp_nxt;
      end
   end

   // Next-state, counter updates and state-decoded outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_chunk_nxt = r_chunk;
      w_grp_nxt   = r_grp;
      in_ready    = 1'b0;
      w_rd_en     = 1'b0;
      w_addr      = '0;
      out_valid   = 1'b0;
      out_idx     = '0;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (en) w_state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_nxt = ST_COMPUTE;
               w_grp_nxt   = '0;
            end
         end
         ST_COMPUTE: begin
            w_rd_en = 1'b1;
            w_addr  = w_row;
            if (w_last_grp) begin
               w_grp_nxt = '0;
               if (w_last_chunk) begin
                  w_state_nxt = ST_DRAIN;
               end else begin
                  w_chunk_nxt = r_chunk + CW'(1);
                  w_state_nxt = ST_LOAD;
               end
            end else begin
               w_grp_nxt = r_grp + GW'(1);
            end
         end
         ST_DRAIN: begin
            if (w_dl_empty) begin
               w_state_nxt = ST_OUTPUT;
               w_grp_nxt   = '0;
            end
         end
         ST_OUTPUT: begin
            out_valid = 1'b1;
            out_idx   = r_grp;
            if (out_ready) begin
               if (w_last_grp) begin
                  done        = 1'b1;
                  w_chunk_nxt = '0;
                  w_grp_nxt   = '0;
                  // en still high at the final transfer chains straight into
                  // the next layer without an idle cycle.
                  w_state_nxt = en ? ST_LOAD : ST_IDLE;
               end else begin
                  w_grp_nxt = r_grp + GW'(1);
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // MAC pipeline tracker: carries {valid, group, first-chunk} from the weight
   // read to the accumulator write so clear/write strobes line up with the data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dl_valid <= '0;
         r_dl_first <= '0;
         r_dl_grp   <= '0;
      end else begin
         r_dl_valid <= {r_dl_valid[DEPTH-2:0], w_rd_en};
         r_dl_first <= {r_dl_first[DEPTH-2:0], (r_chunk == '0)};
         r_dl_grp   <= {r_dl_grp[DEPTH-2:0], r_grp};
      end
   end

   assign pe_en     = r_dl_valid[0];
   assign acc_wr_en = r_dl_valid[DEPTH-1];
   assign acc_addr  = r_dl_valid[DEPTH-1] ? r_dl_grp[DEPTH-1] : '0;
   assign acc_clr   = r_dl_valid[DEPTH-1] & r_dl_first[DEPTH-1];

endmodule

// File: tb/tb_linear_accum_scheduler.sv
// Directed bench for linear_accum_scheduler. A small instance (4 chunks x 4
// groups, PE latency 2) covers sequencing, stalls, backpressure and reset. A
// default-parameter instance covers a full-size layer.
module tb_linear_accum_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, en, in_valid, out_ready;
   logic       in_ready, w_rd_en, pe_en, acc_wr_en, acc_clr, out_valid, done;
   logic [3:0] w_addr;
   logic [1:0] acc_addr, out_idx;

   logic        d_en, d_in_valid, d_out_ready;
   logic        d_in_ready, d_w_rd_en, d_pe_en, d_acc_wr_en, d_acc_clr, d_out_valid, d_done;
   logic [12:0] d_w_addr;
   logic [4:0]  d_acc_addr, d_out_idx;

   int n_cmp = 0;
   int n_err = 0;

   linear_accum_scheduler #(
      .pIN_FEATURE(8), .pOUT_FEATURE(8), .pCHANNEL(2),
      .pOUTPUT_PARALLEL(2), .pPE_LATENCY(2)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
      .w_rd_en(w_rd_en), .w_addr(w_addr), .pe_en(pe_en), .acc_wr_en(acc_wr_en),
      .acc_addr(acc_addr), .acc_clr(acc_clr), .out_valid(out_valid),
      .out_ready(out_ready), .out_idx(out_idx), .done(done)
   );

   linear_accum_scheduler u_dut_def (
      .clk(clk), .rst_n(rst_n), .en(d_en), .in_valid(d_in_valid), .in_ready(d_in_ready),
      .w_rd_en(d_w_rd_en), .w_addr(d_w_addr), .pe_en(d_pe_en), .acc_wr_en(d_acc_wr_en),
      .acc_addr(d_acc_addr), .acc_clr(d_acc_clr), .out_valid(d_out_valid),
      .out_ready(d_out_ready), .out_idx(d_out_idx), .done(d_done)
   );

   // Event log for the small instance, stamped with a cycle index.
   int   cyc = 0;
   int   ir_cnt = 0;
   int   wr_cyc[$], wr_addr[$], pe_cyc[$], aw_cyc[$], aw_addr[$], aw_clr[$];
   int   hs_cyc[$], xf_cyc[$], xf_idx[$], dn_cyc[$];
   logic ov[128];
   logic ordy[128];
   logic [1:0] oi[128];

   always @(negedge clk) begin
      if (w_rd_en) begin wr_cyc.push_back(cyc); wr_addr.push_back(int'(w_addr)); end
      if (pe_en) pe_cyc.push_back(cyc);
      if (acc_wr_en) begin
         aw_cyc.push_back(cyc); aw_addr.push_back(int'(acc_addr)); aw_clr.push_back(int'(acc_clr));
      end
      if (in_valid && in_ready) hs_cyc.push_back(cyc);
      if (in_ready) ir_cnt++;
      if (out_valid && out_ready) begin xf_cyc.push_back(cyc); xf_idx.push_back(int'(out_idx)); end
      if (done) dn_cyc.push_back(cyc);
      if (cyc < 128) begin ov[cyc] = out_valid; oi[cyc] = out_idx; ordy[cyc] = out_ready; end
      cyc++;
   end

   // Running counters for the default-parameter instance.
   int d_cyc = 0, d_wr_n = 0, d_wr_max = 0, d_wr_gap = 0, d_first_wr = -1, d_first_aw = -1;
   int d_aw_n = 0, d_clr_n = 0, d_xf_n = 0, d_idx_bad = 0, d_dn_n = 0, d_dn_cyc = -1;

   always @(negedge clk) begin
      if (d_w_rd_en) begin
         if (d_first_wr < 0) d_first_wr = d_cyc;
         if (int'(d_w_addr) != d_wr_n) d_wr_gap++;
         if (int'(d_w_addr) > d_wr_max) d_wr_max = int'(d_w_addr);
         d_wr_n++;
      end
      if (d_acc_wr_en) begin
         if (d_first_aw < 0) d_first_aw = d_cyc;
         d_aw_n++;
         if (d_acc_clr) d_clr_n++;
      end
      if (d_out_valid && d_out_ready) begin
         if (int'(d_out_idx) != d_xf_n) d_idx_bad++;
         d_xf_n++;
      end
      if (d_done) begin d_dn_n++; d_dn_cyc = d_cyc; end
      d_cyc++;
   end

   task automatic clear_log();
      wr_cyc.delete(); wr_addr.delete(); pe_cyc.delete(); aw_cyc.delete();
      aw_addr.delete(); aw_clr.delete(); hs_cyc.delete(); xf_cyc.delete();
      xf_idx.delete(); dn_cyc.delete();
      cyc = 0; ir_cnt = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      d_en = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({in_ready, w_rd_en, pe_en, acc_wr_en, acc_clr, out_valid, done} !== 7'b0) begin
         n_err++; $display("FAIL reset_strobes: got %b want 0000000",
                           {in_ready, w_rd_en, pe_en, acc_wr_en, acc_clr, out_valid, done});
      end
      n_cmp++;
      if ({w_addr, acc_addr, out_idx} !== 8'b0) begin
         n_err++; $display("FAIL reset_buses: got %h want 00", {w_addr, acc_addr, out_idx});
      end
      n_cmp++;
      if ({d_in_ready, d_w_rd_en, d_out_valid, d_done, d_w_addr} !== 17'b0) begin
         n_err++; $display("FAIL reset_default_inst: got %h want 0",
                           {d_in_ready, d_w_rd_en, d_out_valid, d_done, d_w_addr});
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      clear_log();
      for (int c = 0; c < 4; c++) begin @(posedge clk); #1; end
      n_cmp++;
      if (ir_cnt != 0 || wr_cyc.size() != 0) begin
         n_err++; $display("FAIL idle_without_en: got in_ready cycles %0d reads %0d want 0 0",
                           ir_cnt, wr_cyc.size());
      end
   endtask

   task automatic test_full_layer();
      int exp_hs[4] = '{1, 6, 11, 16};
      clear_log();
      for (int c = 0; c < 35; c++) begin
         en = (c == 0); in_valid = 1'b1; out_ready = 1'b1;
         @(posedge clk); #1;
      end
      en = 1'b0;
      n_cmp++;
      if (hs_cyc.size() != 4) begin
         n_err++; $display("FAIL full_hs_count: got %0d want 4", hs_cyc.size());
      end else for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (hs_cyc[k] != exp_hs[k]) begin
            n_err++; $display("FAIL full_hs_cycle[%0d]: got %0d want %0d", k, hs_cyc[k], exp_hs[k]);
         end
      end
      n_cmp++;
      if (wr_cyc.size() != 16 || pe_cyc.size() != 16 || aw_cyc.size() != 16) begin
         n_err++; $display("FAIL full_counts: got rd %0d pe %0d wr %0d want 16 16 16",
                           wr_cyc.size(), pe_cyc.size(), aw_cyc.size());
      end else for (int k = 0; k < 16; k++) begin
         n_cmp++;
         if (wr_addr[k] != k || wr_cyc[k] != 2 + (k / 4) * 5 + (k % 4)) begin
            n_err++; $display("FAIL full_rd[%0d]: got addr %0d cyc %0d want %0d %0d",
                              k, wr_addr[k], wr_cyc[k], k, 2 + (k / 4) * 5 + (k % 4));
         end
         n_cmp++;
         if (pe_cyc[k] != wr_cyc[k] + 1 || aw_cyc[k] != wr_cyc[k] + 3) begin
            n_err++; $display("FAIL full_latency[%0d]: got pe %0d acc %0d want %0d %0d",
                              k, pe_cyc[k], aw_cyc[k], wr_cyc[k] + 1, wr_cyc[k] + 3);
         end
         n_cmp++;
         if (aw_addr[k] != k % 4 || aw_clr[k] != int'(k < 4)) begin
            n_err++; $display("FAIL full_acc[%0d]: got addr %0d clr %0d want %0d %0d",
                              k, aw_addr[k], aw_clr[k], k % 4, int'(k < 4));
         end
      end
      n_cmp++;
      if (xf_cyc.size() != 4) begin
         n_err++; $display("FAIL full_xfer_count: got %0d want 4", xf_cyc.size());
      end else for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (xf_cyc[k] != 25 + k || xf_idx[k] != k) begin
            n_err++; $display("FAIL full_xfer[%0d]: got cyc %0d idx %0d want %0d %0d",
                              k, xf_cyc[k], xf_idx[k], 25 + k, k);
         end
      end
      n_cmp++;
      if (dn_cyc.size() != 1 || dn_cyc[0] != 28) begin
         n_err++; $display("FAIL full_done: got count %0d want 1 at cycle 28", dn_cyc.size());
      end
   endtask

   task automatic test_in_valid_stall();
      clear_log();
      for (int c = 0; c < 40; c++) begin
         en = (c == 0); in_valid = !(c >= 11 && c <= 15); out_ready = 1'b1;
         @(posedge clk); #1;
      end
      en = 1'b0; in_valid = 1'b1;
      n_cmp++;
      if (ir_cnt != 9) begin
         n_err++; $display("FAIL stall_in_ready_cycles: got %0d want 9", ir_cnt);
      end
      n_cmp++;
      if (hs_cyc.size() != 4 || hs_cyc[2] != 16) begin
         n_err++; $display("FAIL stall_hs: got count %0d want 4 with chunk2 at cycle 16", hs_cyc.size());
      end
      n_cmp++;
      if (wr_cyc.size() != 16) begin
         n_err++; $display("FAIL stall_rd_count: got %0d want 16", wr_cyc.size());
      end else begin
         if (wr_cyc[7] != 10 || wr_cyc[8] != 17 || wr_addr[8] != 8) begin
            n_err++; $display("FAIL stall_resume: got cyc %0d/%0d addr %0d want 10/17 8",
                              wr_cyc[7], wr_cyc[8], wr_addr[8]);
         end
      end
      n_cmp++;
      if (aw_cyc.size() != 16 || aw_cyc[7] != 13 || aw_addr[7] != 3) begin
         n_err++; $display("FAIL stall_drain_during_stall: got count %0d want 16 with write 7 at cycle 13",
                           aw_cyc.size());
      end
      n_cmp++;
      if (dn_cyc.size() != 1 || dn_cyc[0] != 33) begin
         n_err++; $display("FAIL stall_done: got count %0d want 1 at cycle 33", dn_cyc.size());
      end
   endtask

   task automatic test_out_backpressure();
      int exp_xf[4] = '{25, 28, 31, 34};
      clear_log();
      for (int c = 0; c < 40; c++) begin
         en = (c == 0); in_valid = 1'b1;
         out_ready = (c >= 25) ? ((c - 25) % 3 == 0) : 1'b0;
         @(posedge clk); #1;
      end
      en = 1'b0; out_ready = 1'b1;
      n_cmp++;
      if (xf_cyc.size() != 4) begin
         n_err++; $display("FAIL bp_xfer_count: got %0d want 4", xf_cyc.size());
      end else for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (xf_cyc[k] != exp_xf[k] || xf_idx[k] != k) begin
            n_err++; $display("FAIL bp_xfer[%0d]: got cyc %0d idx %0d want %0d %0d",
                              k, xf_cyc[k], xf_idx[k], exp_xf[k], k);
         end
      end
      for (int c = 25; c < 34; c++) begin
         if (!ordy[c]) begin
            n_cmp++;
            if (ov[c + 1] !== 1'b1 || oi[c + 1] !== oi[c]) begin
               n_err++; $display("FAIL bp_hold[%0d]: got valid %b idx %0d want 1 %0d",
                                 c + 1, ov[c + 1], oi[c + 1], oi[c]);
            end
         end
      end
      n_cmp++;
      if (oi[30] !== 2'd2 || ov[35] !== 1'b0) begin
         n_err++; $display("FAIL bp_idx_window: got idx %0d valid_after %b want 2 0", oi[30], ov[35]);
      end
      n_cmp++;
      if (dn_cyc.size() != 1 || dn_cyc[0] != 34) begin
         n_err++; $display("FAIL bp_done: got count %0d want 1 at cycle 34", dn_cyc.size());
      end
   endtask

   task automatic test_reset_midflight();
      clear_log();
      for (int c = 0; c < 9; c++) begin
         en = (c == 0); in_valid = 1'b1; out_ready = 1'b1;
         @(posedge clk); #1;
      end
      en = 1'b0;
      n_cmp++;
      if (w_rd_en !== 1'b1 || w_addr !== 4'd6) begin
         n_err++; $display("FAIL midrst_before: got rd %b addr %0d want 1 6", w_rd_en, w_addr);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({in_ready, w_rd_en, pe_en, acc_wr_en, acc_clr, out_valid, done, w_addr, acc_addr, out_idx} !== 15'b0) begin
         n_err++; $display("FAIL midrst_async_clear: got %h want 0",
                           {in_ready, w_rd_en, pe_en, acc_wr_en, acc_clr, out_valid, done, w_addr, acc_addr, out_idx});
      end
      @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      clear_log();
      for (int c = 0; c < 10; c++) begin @(posedge clk); #1; end
      n_cmp++;
      if (wr_cyc.size() != 0 || aw_cyc.size() != 0 || dn_cyc.size() != 0) begin
         n_err++; $display("FAIL midrst_quiet: got rd %0d acc %0d done %0d want 0 0 0",
                           wr_cyc.size(), aw_cyc.size(), dn_cyc.size());
      end
      clear_log();
      for (int c = 0; c < 35; c++) begin
         en = (c == 0); in_valid = 1'b1; out_ready = 1'b1;
         @(posedge clk); #1;
      end
      en = 1'b0;
      n_cmp++;
      if (wr_cyc.size() != 16 || wr_cyc[0] != 2 || wr_addr[0] != 0) begin
         n_err++; $display("FAIL midrst_restart_rd: got count %0d want 16 first at cycle 2 addr 0", wr_cyc.size());
      end
      n_cmp++;
      if (aw_cyc.size() != 16 || aw_clr[0] != 1 || aw_clr[4] != 0) begin
         n_err++; $display("FAIL midrst_restart_clr: got count %0d want 16 with clr 1 then 0", aw_cyc.size());
      end
      n_cmp++;
      if (dn_cyc.size() != 1 || dn_cyc[0] != 28) begin
         n_err++; $display("FAIL midrst_restart_done: got count %0d want 1 at cycle 28", dn_cyc.size());
      end
   endtask

   task automatic test_back_to_back();
      clear_log();
      for (int c = 0; c < 65; c++) begin
         en = (c <= 40); in_valid = 1'b1; out_ready = 1'b1;
         @(posedge clk); #1;
      end
      en = 1'b0;
      n_cmp++;
      if (dn_cyc.size() != 2 || dn_cyc[0] != 28 || dn_cyc[1] != 56) begin
         n_err++; $display("FAIL b2b_done: got count %0d want 2 at cycles 28 and 56", dn_cyc.size());
      end
      n_cmp++;
      if (hs_cyc.size() != 8 || hs_cyc[4] != 29) begin
         n_err++; $display("FAIL b2b_second_load: got count %0d want 8 with layer-2 first at cycle 29",
                           hs_cyc.size());
      end
      n_cmp++;
      if (wr_cyc.size() != 32 || wr_cyc[16] != 30 || wr_addr[16] != 0 || wr_addr[31] != 15) begin
         n_err++; $display("FAIL b2b_rd: got count %0d want 32 restarting at addr 0 cycle 30", wr_cyc.size());
      end
      n_cmp++;
      if (aw_clr.size() != 32 || aw_clr[12] != 0 || aw_clr[16] != 1 || aw_clr[19] != 1 || aw_clr[20] != 0) begin
         n_err++; $display("FAIL b2b_clr: got count %0d want 32 with clr on writes 16..19 only", aw_clr.size());
      end
   endtask

   task automatic test_default_params();
      d_cyc = 0; d_wr_n = 0; d_wr_max = 0; d_wr_gap = 0; d_first_wr = -1; d_first_aw = -1;
      d_aw_n = 0; d_clr_n = 0; d_xf_n = 0; d_idx_bad = 0; d_dn_n = 0; d_dn_cyc = -1;
      for (int c = 0; c < 6520; c++) begin
         d_en = (c == 0); d_in_valid = 1'b1; d_out_ready = 1'b1;
         @(posedge clk); #1;
      end
      d_en = 1'b0;
      n_cmp++;
      if (d_wr_n != 6272 || d_wr_gap != 0 || d_wr_max != 6271) begin
         n_err++; $display("FAIL def_rd: got count %0d gaps %0d max %0d want 6272 0 6271",
                           d_wr_n, d_wr_gap, d_wr_max);
      end
      n_cmp++;
      if (d_first_wr != 2 || d_first_aw != 6) begin
         n_err++; $display("FAIL def_latency: got rd %0d acc %0d want 2 6", d_first_wr, d_first_aw);
      end
      n_cmp++;
      if (d_aw_n != 6272 || d_clr_n != 32) begin
         n_err++; $display("FAIL def_acc: got writes %0d clears %0d want 6272 32", d_aw_n, d_clr_n);
      end
      n_cmp++;
      if (d_xf_n != 32 || d_idx_bad != 0) begin
         n_err++; $display("FAIL def_out: got transfers %0d bad idx %0d want 32 0", d_xf_n, d_idx_bad);
      end
      n_cmp++;
      if (d_dn_n != 1 || d_dn_cyc != 6505) begin
         n_err++; $display("FAIL def_done: got count %0d cycle %0d want 1 6505", d_dn_n, d_dn_cyc);
      end
   endtask

   initial begin
      test_reset();
      test_full_layer();
      test_in_valid_stall();
      test_out_backpressure();
      test_reset_midflight();
      test_back_to_back();
      test_default_params();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
